fsk_modulate: RTL and testbench
===============================

# fsk_modulate

Transmit end of the Hamming/FSK/PCM link: accepts a 14-bit Hamming codeword and sends it serially as a frequency-shift-keyed square wave, together with the bit-rate framing strobe the demodulator uses to count pulses. A mark ('1') is a fast carrier and a space ('0') is a slow carrier. It sits between the Hamming encoder and the channel, and drives `fsk_signal` and `clk_bitTransferRate` into the receiver.

## Interface
- `HALF_BIT`, 48: system clocks per half bit period; full bit period is 2*HALF_BIT.
- `MARK_HALF`, 4: carrier half-period in clocks for a '1'.
- `SPACE_HALF`, 12: carrier half-period in clocks for a '0'.

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high.
- `Hamcode` input 14: codeword to send; sampled only on accept.
- `start` input 1: request to send `Hamcode`.
- `ready` output 1: high when a `start` will be accepted.
- `fsk_signal` output 1: FSK carrier.
- `clk_bitTransferRate` output 1: high for the first HALF_BIT clocks of each bit period, low for the second.
- `done` output 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE, SEND.
- IDLE:
  - `ready`=1, `fsk_signal`=0, `clk_bitTransferRate`=0.
  - `start`=1 latches `Hamcode` into the shift register, clears the bit index, cycle counter and carrier phase, and enters SEND.
- SEND:
  - Bits are sent LSB first, bit 0 through bit 13.
  - Cycle counter runs 0..2*HALF_BIT-1 per bit. `clk_bitTransferRate` = (cycle < HALF_BIT).
  - Carrier:
    - Restarts at the beginning of every bit with `fsk_signal`=0 and the phase counter at 0.
    - Toggles every MARK_HALF clocks for a '1' and every SPACE_HALF clocks for a '0'.
    - Runs through both halves of the bit.
  - With defaults, a '1' gives 6 rising edges in the high half and a '0' gives 2. Both satisfy the receiver's 3-bit count with a threshold of >3.
  - After the last cycle of bit 13: enter IDLE, pulse `done`, assert `ready`.
- `start` is ignored in SEND; `ready`=0 throughout SEND.
- `Hamcode` changes after accept have no effect on the frame in flight.
- Legal parameters: 1 ≤ MARK_HALF < SPACE_HALF, and 2*SPACE_HALF ≤ HALF_BIT. 2*MARK_HALF must give 4..7 rising edges per high half. Out-of-range values are unsupported and not checked in RTL.
- `reset` asserted at any time, including mid-frame, aborts the frame immediately:
  - State → IDLE.
  - `ready`=1, `done`=0, `fsk_signal`=0, `clk_bitTransferRate`=0, all counters 0.
  - After release, no partial frame is resumed.

## Timing
- Reset values: `ready`=1, `done`=0, `fsk_signal`=0, `clk_bitTransferRate`=0.
- All outputs are registered.
- Accept at rising edge k, where `start`=1 and `ready`=1. From edge k+1:
  - `ready`=0.
  - `clk_bitTransferRate`=1 (bit 0, cycle 0).
  - `fsk_signal`=0.
- First carrier rise: edge k+1+MARK_HALF (bit 0 = '1') or k+1+SPACE_HALF (bit 0 = '0').
- Bit n starts at edge k+1+n*2*HALF_BIT.
- Frame length is 14*2*HALF_BIT = 1344 clocks (defaults).
- `done`=1 and `ready`=1 at edge k+1+1344, for one cycle. `fsk_signal` and `clk_bitTransferRate` return to 0 at that edge.
- `start` high during the `done` cycle is accepted, so the minimum gap between frames is one IDLE cycle.
- Throughput: one frame per 1345 clocks.

## Structure
- Shared package `fsk_pkg` holds:
  - `FRAME_BITS`=14.
  - The state encoding (IDLE, SEND).
  - Default HALF_BIT, MARK_HALF and SPACE_HALF.
  - `fsk_demodulate` uses the same constants.
- One sub-module, `fsk_carrier_gen`:
  - Inputs: `clk`, `reset`, `restart`, `mark`.
  - Output: square wave.
  - Internal phase counter with half-period selected by `mark`.
- The top level holds the FSM, shift register, bit index and bit-period counter.

## Test plan
- Reset then `Hamcode`=14'h3FFF with `start` → 14 bits, each with exactly 6 rising edges while `clk_bitTransferRate`=1; `done` at accept+1345.
- `Hamcode`=14'h0000 → each bit has exactly 2 rising edges in the high half; `clk_bitTransferRate` period is 96 clocks.
- `Hamcode`=14'h2A55, looped back into `fsk_demodulate` → receiver-decoded bits match the sent bits in LSB-first order; edge counts per bit are 6/2 as expected.
- `start` pulsed mid-frame and `Hamcode` changed mid-frame → ignored; frame content unchanged; `ready` stays 0 until `done`.
- `reset` asserted at bit 7, cycle 30 → all outputs 0 and `ready`=1 asynchronously; a new `start` after release sends a full 14-bit frame from bit 0.
- `start` held high continuously → frames back-to-back with exactly one IDLE cycle, on which `done`=1, between them.

Source files
------------

// File: rtl/fsk_pkg.sv
// fsk_pkg: constants and state encoding shared by the FSK transmitter and receiver.
//   FRAME_BITS      : bits per Hamming codeword frame
//   *_DEF           : default timing, in system clocks
//   fsk_state_e     : transmitter FSM state encoding
package fsk_pkg;

  localparam int FRAME_BITS     = 14;
  localparam int HALF_BIT_DEF   = 48;
  localparam int MARK_HALF_DEF  = 4;
  localparam int SPACE_HALF_DEF = 12;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsk_state_e;

endpackage

// File: rtl/fsk_carrier_gen.sv
// fsk_carrier_gen: square-wave carrier whose half-period is picked per bit.
//   clk     in  : system clock
//   reset   in  : asynchronous, active-high
//   restart in  : force phase 0 with the wave low (bit boundary or idle)
//   mark    in  : 1 selects MARK_HALF, 0 selects SPACE_HALF
//   wave    out : registered carrier
module fsk_carrier_gen
  import fsk_pkg::*;
#(
  parameter int MARK_HALF  = MARK_HALF_DEF,
  parameter int SPACE_HALF = SPACE_HALF_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic mark,
  output logic wave
);

  localparam int PH_W = (SPACE_HALF > 1) ? $clog2(SPACE_HALF) : 1;

  logic [PH_W-1:0] phase;
  logic [PH_W-1:0] half_last;

  assign half_last = mark ? PH_W'(MARK_HALF - 1) : PH_W'(SPACE_HALF - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      wave  <= 1'b0;
    end else if (restart) begin
      phase <= '0;
      wave  <= 1'b0;
    end else if (phase == half_last) begin
      phase <= '0;
      wave  <= ~wave;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/fsk_modulate.sv
// fsk_modulate: serialises a 14-bit Hamming codeword LSB first as an FSK
// square wave plus the bit-rate framing strobe used by the receiver.
//   clk                 in      : system clock
//   reset               in      : asynchronous, active-high
//   Hamcode             in [14] : codeword, sampled on accept
//   start               in      : send request
//   ready               out     : start will be accepted
//   fsk_signal          out     : FSK carrier
//   clk_bitTransferRate out     : high for the first HALF_BIT clocks of a bit
//   done                out     : one-cycle end-of-frame pulse
//
// state | meaning
// IDLE  | waiting for start; outputs quiet, ready high
// SEND  | shifting out bits, one per 2*HALF_BIT clocks
module fsk_modulate
  import fsk_pkg::*;
#(
  parameter int HALF_BIT   = HALF_BIT_DEF,
  parameter int MARK_HALF  = MARK_HALF_DEF,
  parameter int SPACE_HALF = SPACE_HALF_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] Hamcode,
  input  logic                  start,
  output logic                  ready,
  output logic                  fsk_signal,
  output logic                  clk_bitTransferRate,
  output logic                  done
);

  localparam int CYC_W = $clog2(2 * HALF_BIT);
  localparam int IDX_W = $clog2(FRAME_BITS);

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(2 * HALF_BIT - 1);
  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  fsk_state_e            state;
  logic [FRAME_BITS-1:0] shreg;
  logic [IDX_W-1:0]      bit_idx;
  logic [CYC_W-1:0]      cycle;
  logic                  carrier_restart;

  // The carrier is held in restart while idle and on the last cycle of each
  // bit, so every bit (including bit 0) begins low with phase 0.
  assign carrier_restart = (state == IDLE) || (cycle == CYC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      shreg               <= '0;
      bit_idx             <= '0;
      cycle               <= '0;
      ready               <= 1'b1;
      done                <= 1'b0;
      clk_bitTransferRate <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ready               <= 1'b1;
          clk_bitTransferRate <= 1'b0;
          if (start) begin
            state               <= SEND;
            shreg               <= Hamcode;
            bit_idx             <= '0;
            cycle               <= '0;
            ready               <= 1'b0;
            clk_bitTransferRate <= 1'b1;
          end
        end
        SEND: begin
          if (cycle == CYC_LAST) begin
            cycle <= '0;
            if (bit_idx == IDX_LAST) begin
              state               <= IDLE;
              ready               <= 1'b1;
              done                <= 1'b1;
              clk_bitTransferRate <= 1'b0;
            end else begin
              bit_idx             <= bit_idx + 1'b1;
              shreg               <= shreg >> 1;
              clk_bitTransferRate <= 1'b1;
            end
          end else begin
            cycle <= cycle + 1'b1;
            if (cycle == CYC_HALF) clk_bitTransferRate <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fsk_carrier_gen #(
    .MARK_HALF  (MARK_HALF),
    .SPACE_HALF (SPACE_HALF)
  ) u_carrier (
    .clk     (clk),
    .reset   (reset),
    .restart (carrier_restart),
    .mark    (shreg[0]),
    .wave    (fsk_signal)
  );

endmodule

// File: tb/tb_fsk_modulate.sv
module tb_fsk_modulate;

  localparam int FRAME_BITS = 14;
  localparam int HALF_BIT   = 48;
  localparam int MARK_HALF  = 4;
  localparam int SPACE_HALF = 12;
  localparam int FRAME_CLKS = FRAME_BITS * 2 * HALF_BIT;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] Hamcode;
  logic        start;
  logic        ready;
  logic        fsk_signal;
  logic        clk_bitTransferRate;
  logic        done;

  fsk_modulate dut (
    .clk                 (clk),
    .reset               (reset),
    .Hamcode             (Hamcode),
    .start               (start),
    .ready               (ready),
    .fsk_signal          (fsk_signal),
    .clk_bitTransferRate (clk_bitTransferRate),
    .done                (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Receiver-side view of the spec: a bit of half-period h rises at
  // h, 3h, 5h, ... after the bit starts; count those inside the high half.
  function automatic int exp_rises(input logic b);
    int h = b ? MARK_HALF : SPACE_HALF;
    int n = 0;
    for (int t = h; t < HALF_BIT; t += 2 * h) n++;
    return n;
  endfunction

  typedef struct {
    logic [13:0] word;
    int          acc;
  } exp_t;

  exp_t q[$];

  // ---------------- monitor ----------------
  int          nbits = 0;
  int          rises = 0;
  int          bit_start = 0;
  int          last_done = -100;
  int          edges[FRAME_BITS];
  logic [13:0] dec = '0;
  logic        ready_bad = 1'b0;
  logic        prev_cbtr = 1'b0;
  logic        prev_fsk  = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      nbits = 0; rises = 0; dec = '0; ready_bad = 1'b0;
      prev_cbtr = 1'b0; prev_fsk = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", int'(done), 0);
      if (q.size() > 0 && !done && ready) ready_bad = 1'b1;
      if (clk_bitTransferRate && !prev_cbtr) begin
        if (nbits > 0) check("bit_period", cyc - bit_start, 2 * HALF_BIT);
        bit_start = cyc;
        rises = 0;
      end else if (clk_bitTransferRate && fsk_signal && !prev_fsk) begin
        rises++;
      end
      if (!clk_bitTransferRate && prev_cbtr) begin
        if (nbits < FRAME_BITS) begin
          edges[nbits] = rises;
          dec[nbits]   = (rises > 3);
        end
        nbits++;
      end
      if (done) begin
        check("frame_pending", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          logic [13:0] w;
          e = q.pop_front();
          w = e.word;
          check("decoded_word", int'(dec), int'(w));
          check("bits_in_frame", nbits, FRAME_BITS);
          check("done_latency", cyc - e.acc, FRAME_CLKS);
          check("ready_at_done", int'(ready), 1);
          check("ready_low_in_frame", int'(ready_bad), 0);
          for (int i = 0; i < FRAME_BITS; i++)
            check($sformatf("edges_bit%0d", i), edges[i], exp_rises(w[i]));
        end
        last_done = cyc;
        nbits = 0; dec = '0; ready_bad = 1'b0;
      end
      prev_cbtr = clk_bitTransferRate;
      prev_fsk  = fsk_signal;
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", int'(ready), 1);
  endtask

  task automatic send(input logic [13:0] word, input bit noise);
    exp_t e;
    wait_ready();
    Hamcode = word;
    start   = 1'b1;
    @(posedge clk); #1;
    e.word = word;
    e.acc  = cyc;
    q.push_back(e);
    start = 1'b0;
    if (noise) begin
      repeat (20) begin
        repeat ($urandom_range(10, 50)) @(posedge clk);
        #1;
        start   = 1'b1;
        Hamcode = 14'($urandom);
        @(posedge clk); #1;
        start   = 1'b0;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    Hamcode = '0;
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_fsk", int'(fsk_signal), 0);
    check("rst_cbtr", int'(clk_bitTransferRate), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    send(14'h3FFF, 1'b0);
    send(14'h0000, 1'b0);
    send(14'h2A55, 1'b0);
    send(14'($urandom), 1'b1);
    send(14'($urandom), 1'b1);

    // abort at bit 7, cycle 30
    send(14'($urandom), 1'b0);
    repeat (7 * 2 * HALF_BIT + 30) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    check("abort_fsk", int'(fsk_signal), 0);
    check("abort_cbtr", int'(clk_bitTransferRate), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_abort_idle_cbtr", int'(clk_bitTransferRate), 0);
    check("post_abort_idle_ready", int'(ready), 1);
    send(14'($urandom), 1'b0);

    // start held high: frames back-to-back with one done cycle between
    start = 1'b1;
    for (int f = 0; f < 4; f++) begin
      exp_t e;
      wait_ready();
      Hamcode = 14'($urandom);
      e.word  = Hamcode;
      @(posedge clk); #1;
      e.acc = cyc;
      q.push_back(e);
      if (f > 0) check("b2b_gap", cyc - last_done, 1);
    end
    start = 1'b0;

    repeat (3) send(14'($urandom), 1'b0);

    begin
      int n = 0;
      while (q.size() > 0 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("queue_drained", q.size(), 0);
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
